cmp_filter_tdm: RTL and testbench

Parametrised, time-multiplexed complementary filter for N attitude channels. It is the successor to the fixed three-axis `cmp_filter` and adds three things: true gyro integration with per-channel state, a runtime-programmable blend coefficient, and saturating fixed-point arithmetic. It sits between the IMU scaling stage and the attitude PID loop. It uses one shared multiplier and processes one channel per clock.

---
 rtl/cmp_filter_pkg.sv | 15 +
 rtl/cmp_blend_unit.sv | 28 ++
 rtl/cmp_filter_tdm.sv | 84 ++++++++
 tb/tb_cmp_filter_tdm.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_filter_pkg.sv
// cmp_filter_pkg: shared FSM states, default parameters and saturation helper for the complementary filter
package cmp_filter_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} fsm_t;
    localparam int DEF_N_CH = 3;
    localparam int DEF_W = 24;
    localparam int DEF_AW = 8;
    localparam int DEF_DT_SHIFT = 0;
    localparam logic [2:0] DEF_ACC_MASK = 3'b011;
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return v > hi ? hi : v < lo ? lo : v;
    endfunction
endpackage

// File: rtl/cmp_blend_unit.sv
// cmp_blend_unit: one channel of predict (gyro integration), accelerometer blend and saturation
module cmp_blend_unit import cmp_filter_pkg::*; #(
    parameter int W = DEF_W,
    parameter int AW = DEF_AW,
    parameter int DT_SHIFT = DEF_DT_SHIFT
) (
    input  logic signed [W-1:0] state,
    input  logic signed [W-1:0] gyro,
    input  logic signed [W-1:0] acc,
    input  logic [AW:0]         alpha,
    input  logic                blend_en,
    output logic signed [W-1:0] result
);
    localparam int PW = W + AW + 3;
    logic signed [W:0]    sum;
    logic signed [W-1:0]  pred;
    logic signed [W+1:0]  diff;
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] bl;
    always_comb begin
        sum = (W+1)'(state) + (W+1)'(gyro >>> DT_SHIFT);
        pred = W'(sat(64'(sum), W));
        diff = (W+2)'(pred) - (W+2)'(acc);
        p = PW'(diff) * PW'($signed({1'b0, alpha}));
        bl = PW'(acc) + (p >>> AW);
        result = blend_en ? W'(sat(64'(bl), W)) : pred;
    end
endmodule

// File: rtl/cmp_filter_tdm.sv
// cmp_filter_tdm: time-multiplexed N-channel complementary filter, one channel per clock through a shared blend unit
module cmp_filter_tdm import cmp_filter_pkg::*; #(
    parameter int N_CH = DEF_N_CH,
    parameter int W = DEF_W,
    parameter int AW = DEF_AW,
    parameter int DT_SHIFT = DEF_DT_SHIFT,
    parameter logic [N_CH-1:0] ACC_MASK = N_CH'(DEF_ACC_MASK)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_CH*W-1:0] gyro_bus,
    input  logic [N_CH*W-1:0] acc_bus,
    input  logic [AW:0]       alpha,
    output logic [N_CH*W-1:0] angle_bus,
    output logic              out_valid,
    output logic              busy
);
    localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam logic [AW:0] A_MAX = (AW+1)'(1) << AW;
    fsm_t              fsm;
    logic [CW-1:0]     ch;
    logic [N_CH*W-1:0] gyro_q;
    logic [N_CH*W-1:0] acc_q;
    logic [AW:0]       alpha_q;
    logic [N_CH*W-1:0] st;
    logic signed [W-1:0] res;

    assign in_ready = fsm == IDLE;
    assign busy = fsm != IDLE;

    cmp_blend_unit #(.W(W), .AW(AW), .DT_SHIFT(DT_SHIFT)) u_blend (
        .state(st[ch*W +: W]),
        .gyro(gyro_q[ch*W +: W]),
        .acc(acc_q[ch*W +: W]),
        .alpha(alpha_q),
        .blend_en(ACC_MASK[ch]),
        .result(res)
    );

    // angle_bus only moves in DONE so every channel updates in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
            ch <= '0;
            gyro_q <= '0;
            acc_q <= '0;
            alpha_q <= '0;
            st <= '0;
            angle_bus <= '0;
            out_valid <= 1'b0;
        end else if (clr) begin
            fsm <= IDLE;
            ch <= '0;
            st <= '0;
            angle_bus <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (fsm)
                IDLE: if (in_valid) begin
                    gyro_q <= gyro_bus;
                    acc_q <= acc_bus;
                    alpha_q <= alpha > A_MAX ? A_MAX : alpha;
                    ch <= '0;
                    fsm <= CALC;
                end
                CALC: begin
                    st[ch*W +: W] <= res;
                    if (ch == CW'(N_CH - 1)) fsm <= DONE;
                    else ch <= ch + CW'(1);
                end
                DONE: begin
                    angle_bus <= st;
                    out_valid <= 1'b1;
                    fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_filter_tdm.sv
// tb_cmp_filter_tdm: randomized and directed checks of cmp_filter_tdm against an arithmetic reference model
module tb_cmp_filter_tdm;
    localparam int N = 3;
    localparam int W = 24;
    localparam int AW = 8;
    localparam int DT = 0;
    localparam longint SMAX = 8388607;
    localparam longint SMIN = -8388608;

    logic clk = 0, rst_n = 0, clr = 0, in_valid = 0;
    logic in_ready, out_valid, busy;
    logic [N*W-1:0] gyro_bus = '0, acc_bus = '0, angle_bus;
    logic [AW:0] alpha = '0;
    logic [2:0] mask = 3'b011;

    longint mst[N], shown[N], pend[N], tg[N], ta[N];
    int talpha;
    int acc_edge = -100;
    int cyc = 0;
    int vectors = 0, miscompares = 0;
    bit eb, eo;

    cmp_filter_tdm dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .gyro_bus(gyro_bus), .acc_bus(acc_bus), .alpha(alpha),
        .angle_bus(angle_bus), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint satw(input longint v);
        return v > SMAX ? SMAX : v < SMIN ? SMIN : v;
    endfunction

    function automatic longint ang(input int i);
        logic signed [W-1:0] t;
        t = angle_bus[i*W +: W];
        return t;
    endfunction

    function automatic longint rnd_full();
        logic signed [W-1:0] t;
        t = W'($urandom);
        return t;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mst[i] = 0;
            shown[i] = 0;
        end
        acc_edge = -100;
    endtask

    task automatic model_accept();
        longint al, pred;
        al = talpha > 256 ? 256 : talpha;
        for (int i = 0; i < N; i++) begin
            pred = satw(mst[i] + (tg[i] >>> DT));
            mst[i] = mask[i] ? satw(ta[i] + (((pred - ta[i]) * al) >>> AW)) : pred;
            pend[i] = mst[i];
        end
        acc_edge = cyc;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            gyro_bus[i*W +: W] = W'(tg[i]);
            acc_bus[i*W +: W] = W'(ta[i]);
        end
        alpha = (AW+1)'(talpha);
    endtask

    task automatic scramble();
        gyro_bus = {W'($urandom), W'($urandom), W'($urandom)};
        acc_bus = {W'($urandom), W'($urandom), W'($urandom)};
        alpha = (AW+1)'($urandom);
    endtask

    // accept one frame, optionally keep in_valid high for `hold` more edges, wait for its DONE edge
    task automatic send(input int hold, input bit scr);
        drive_inputs();
        in_valid = 1;
        @(posedge clk); #1;
        model_accept();
        if (scr) scramble();
        repeat (hold) begin
            @(posedge clk); #1;
        end
        in_valid = 0;
        while (cyc < acc_edge + 4) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_clear();
        clr = 1;
        @(posedge clk); #1;
        clr = 0;
        model_clear();
    endtask

    task automatic set_all(input longint g, input longint a, input int al);
        for (int i = 0; i < N; i++) begin
            tg[i] = g;
            ta[i] = a;
        end
        talpha = al;
    endtask

    always @(negedge clk) begin
        eb = cyc >= acc_edge && cyc <= acc_edge + 3;
        eo = cyc == acc_edge + 4;
        if (eo) for (int i = 0; i < N; i++) shown[i] = pend[i];
        chk("busy", longint'(busy), longint'(eb));
        chk("in_ready", longint'(in_ready), longint'(!eb));
        chk("out_valid", longint'(out_valid), longint'(eo));
        for (int i = 0; i < N; i++) chk($sformatf("angle%0d", i), ang(i), shown[i]);
    end

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        set_all(1234, 777, 256);
        send(0, 0);
        for (int i = 0; i < N; i++) chk("gyro_f1", ang(i), 1234);
        send(0, 0);
        for (int i = 0; i < N; i++) chk("gyro_f2", ang(i), 2468);

        do_clear();
        set_all(-10000, -10000, 0);
        send(0, 0);
        for (int i = 0; i < N; i++) chk("acc_f1", ang(i), -10000);
        send(0, 0);
        chk("acc_f2_ch0", ang(0), -10000);
        chk("acc_f2_ch1", ang(1), -10000);
        chk("acc_f2_ch2", ang(2), -20000);

        do_clear();
        set_all(400, 1000, 192);
        send(0, 0);
        chk("blend_550", ang(0), 550);
        chk("blend_ch2", ang(2), 400);
        do_clear();
        set_all(1, 0, 192);
        send(0, 0);
        chk("blend_pos_floor", ang(1), 0);
        do_clear();
        set_all(-1, 0, 192);
        send(0, 0);
        chk("blend_neg_floor", ang(0), -1);

        do_clear();
        set_all(8388000, 5, 256);
        send(0, 0);
        set_all(1000, 5, 256);
        send(0, 0);
        for (int i = 0; i < N; i++) chk("sat_hi", ang(i), 8388607);
        do_clear();
        set_all(-8388000, 5, 256);
        send(0, 0);
        set_all(-1000, 5, 256);
        send(0, 0);
        for (int i = 0; i < N; i++) chk("sat_lo", ang(i), -8388608);

        set_all(50, 60, 400);
        send(4, 1);

        drive_inputs();
        in_valid = 1;
        @(posedge clk); #1;
        model_accept();
        in_valid = 0;
        @(posedge clk); #1;
        do_clear();
        chk("clr_ready", longint'(in_ready), 1);
        chk("clr_angle0", ang(0), 0);

        set_all(300, 300, 128);
        drive_inputs();
        in_valid = 1;
        clr = 1;
        @(posedge clk); #1;
        in_valid = 0;
        clr = 0;
        model_clear();
        chk("clr_wins", longint'(busy), 0);

        set_all(900, -900, 100);
        send(0, 0);
        drive_inputs();
        in_valid = 1;
        @(posedge clk); #1;
        model_accept();
        in_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        model_clear();
        @(posedge clk); #1;
        chk("rst_ready", longint'(in_ready), 1);
        chk("rst_angle2", ang(2), 0);
        rst_n = 1;
        repeat (6) begin
            @(posedge clk); #1;
        end

        repeat (60) begin
            for (int i = 0; i < N; i++) begin
                tg[i] = $urandom_range(0, 3) == 0 ? rnd_full() : longint'($urandom_range(0, 40000)) - 20000;
                ta[i] = $urandom_range(0, 3) == 0 ? rnd_full() : longint'($urandom_range(0, 40000)) - 20000;
            end
            talpha = $urandom_range(0, 511);
            if ($urandom_range(0, 9) == 0) begin
                drive_inputs();
                in_valid = 1;
                @(posedge clk); #1;
                model_accept();
                in_valid = 0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
                do_clear();
            end else begin
                send($urandom_range(0, 4), 1);
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
